deser_fifo: RTL and testbench

DESER_FIFO -- requirements
Module: deser_fifo

---
 rtl/deser_fifo_pkg.sv | 17 +
 rtl/deser_fifo_shifter.sv | 76 +++++++
 rtl/deser_fifo.sv | 133 +++++++++++++
 tb/tb_deser_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_fifo_pkg : shared types and default sizes for deser_fifo       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package deser_fifo_pkg;

  localparam int c_DEF_DATA_W = 8;
  localparam int c_DEF_DEPTH  = 8;

  typedef enum logic [0:0] {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/deser_fifo_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_fifo_shifter : serial-to-parallel shifter, bit counter, FSM    |
// | Bit order set by DESER_FIFO_MSB_FIRST_EN (LSB first when undefined). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module deser_fifo_shifter
  import deser_fifo_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bit_valid,
  input  logic              i_bit,
  input  logic              i_enq_ok,
  output logic [DATA_W-1:0] o_word,
  output logic              o_hold,
  output logic              o_status
);

  localparam int               CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_take;

  assign w_take = (r_state == RECV) && i_bit_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RECV;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RECV:    if (i_bit_valid && (r_cnt == c_LAST)) w_state_nxt = HOLD;
      HOLD:    if (i_enq_ok) w_state_nxt = RECV;
      default: w_state_nxt = RECV;
    endcase
  end

  always_comb begin
    o_status = (r_state == RECV);
    o_hold   = (r_state == HOLD);
  end

  // Word stays frozen in HOLD until the queue accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
`ifdef DESER_FIFO_MSB_FIRST_EN
      r_shift <= {r_shift[DATA_W-2:0], i_bit};
`else
      r_shift <= {i_bit, r_shift[DATA_W-1:1]};
`endif
      r_cnt   <= r_cnt + c_ONE;
    end else if (i_enq_ok) begin
      r_cnt   <= '0;
    end
  end

  assign o_word = r_shift;

endmodule
`default_nettype wire

// File: rtl/deser_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_fifo : strobed serial deserializer feeding a circular queue    |
// | Optional macro DESER_FIFO_MSB_FIRST_EN selects MSB-first bit order.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module deser_fifo
  import deser_fifo_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int DEPTH  = c_DEF_DEPTH
) (
  input  logic                  clock_1MHz,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  write_in,
  input  logic                  enqueue_in,
  input  logic                  dequeue_in,
  output logic                  status_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  overflow_out
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_PONE = PTR_W'(1);

  // Lane order: [0] write, [1] enqueue, [2] dequeue, [3] data.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [2:0] r_prev;
  logic [2:0] r_armed;
  logic [1:0] r_warm;
  logic [2:0] w_rise;

  // A lane arms only after a genuine low has reached sync2, so a strobe
  // already high when reset releases does not count as an edge.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_armed <= '0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= {data_in, dequeue_in, enqueue_in, write_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2[2:0];
      r_warm  <= {r_warm[0], 1'b1};
      r_armed <= r_armed | ({3{r_warm[1]}} & ~r_sync2[2:0]);
    end
  end

  assign w_rise = r_sync2[2:0] & ~r_prev & r_armed;

  logic [DATA_W-1:0] w_word;
  logic              w_hold;
  logic              w_enq_req;
  logic              w_enq_do;
  logic              w_deq_do;
  logic              w_ovf;

  deser_fifo_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk         (clock_1MHz),
    .rst         (rst),
    .i_bit_valid (w_rise[0]),
    .i_bit       (r_sync2[3]),
    .i_enq_ok    (w_enq_do),
    .o_word      (w_word),
    .o_hold      (w_hold),
    .o_status    (status_out)
  );

  // A same-cycle pop frees the slot, so a push into a full queue succeeds.
  assign w_deq_do  = w_rise[2] && !empty_out;
  assign w_enq_req = w_rise[1] && w_hold;
  assign w_enq_do  = w_enq_req && (!full_out || w_deq_do);
  assign w_ovf     = w_enq_req && full_out && !w_deq_do;

  logic [CNT_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  always_comb begin
    w_count_nxt = count_out;
    if (w_enq_do && !w_deq_do) begin
      w_count_nxt = count_out + c_ONE;
    end else if (!w_enq_do && w_deq_do) begin
      w_count_nxt = count_out - c_ONE;
    end
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock_1MHz) begin
    if (w_enq_do) begin
      r_mem[r_tail] <= w_word;
    end
  end

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      count_out    <= '0;
      full_out     <= 1'b0;
      empty_out    <= 1'b1;
      data_out     <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (w_enq_do) begin
        r_tail <= r_tail + c_PONE;
      end
      if (w_deq_do) begin
        data_out <= r_mem[r_head];
        r_head   <= r_head + c_PONE;
      end
      count_out    <= w_count_nxt;
      full_out     <= (w_count_nxt == c_FULL);
      empty_out    <= (w_count_nxt == '0);
      overflow_out <= w_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deser_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_deser_fifo : directed, table-driven bench for deser_fifo          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_deser_fifo;

  localparam int OP_SEND_ENQ = 0;
  localparam int OP_ENQ      = 1;
  localparam int OP_DEQ      = 2;
  localparam int OP_BOTH     = 3;

  logic       clock_1MHz = 1'b0;
  logic       rst        = 1'b0;
  logic       data_in    = 1'b0;
  logic       write_in   = 1'b0;
  logic       enqueue_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       status_out;
  logic [7:0] data_out;
  logic [3:0] count_out;
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_seen = 0;

  typedef struct {
    int         op;
    logic [7:0] word;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       status;
  } vec_t;

  vec_t vecs[$];
  int   split;

  always #5 clock_1MHz = ~clock_1MHz;

  always @(negedge clock_1MHz) begin
    if (overflow_out === 1'b1) ovf_seen <= ovf_seen + 1;
  end

  deser_fifo #(
    .DATA_W (8),
    .DEPTH  (8)
  ) dut (
    .clock_1MHz   (clock_1MHz),
    .rst          (rst),
    .data_in      (data_in),
    .write_in     (write_in),
    .enqueue_in   (enqueue_in),
    .dequeue_in   (dequeue_in),
    .status_out   (status_out),
    .data_out     (data_out),
    .count_out    (count_out),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .overflow_out (overflow_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock_1MHz);
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    wait_n(2);
    write_in = 1'b0;
    wait_n(2);
  endtask

  // Order chosen so the assembled word equals w in either build.
  task automatic send_bit_idx(input logic [7:0] w, input int i);
`ifdef DESER_FIFO_MSB_FIRST_EN
    send_bit(w[7-i]);
`else
    send_bit(w[i]);
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit_idx(w, i);
  endtask

  task automatic pulse(input logic enq, input logic deq);
    enqueue_in = enq;
    dequeue_in = deq;
    wait_n(2);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    wait_n(2);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int ovf0;
    ovf0 = ovf_seen;
    case (v.op)
      OP_SEND_ENQ: begin send_word(v.word); pulse(1'b1, 1'b0); end
      OP_ENQ:      pulse(1'b1, 1'b0);
      OP_DEQ:      pulse(1'b0, 1'b1);
      default:     begin send_word(v.word); pulse(1'b1, 1'b1); end
    endcase
    chk($sformatf("v%0d_data", idx),   data_out,   v.dout);
    chk($sformatf("v%0d_count", idx),  count_out,  v.cnt);
    chk($sformatf("v%0d_full", idx),   full_out,   v.full);
    chk($sformatf("v%0d_empty", idx),  empty_out,  v.empty);
    chk($sformatf("v%0d_status", idx), status_out, v.status);
    chk($sformatf("v%0d_noovf", idx),  ovf_seen,   ovf0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [7:0] w;

    // Part A: drain the 8'h81 word, then fill the queue with 80..87.
    vecs.push_back('{OP_DEQ, 8'h00, 8'h81, 4'd0, 1'b0, 1'b1, 1'b1});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{OP_SEND_ENQ, 8'(8'h80 + i), 8'h81, 4'(i + 1), (i == 7), 1'b0, 1'b1});
    split = vecs.size();
    // Part B: after the overflow attempt on 8'hF0.
    vecs.push_back('{OP_DEQ, 8'h00, 8'h80, 4'd7, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_ENQ, 8'h00, 8'h80, 4'd8, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{OP_DEQ, 8'h00, 8'(8'h81 + i), 4'(7 - i), 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_BOTH, 8'h3C, 8'h86, 4'd3, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_DEQ, 8'h00, 8'h87, 4'd2, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_DEQ, 8'h00, 8'hF0, 4'd1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_DEQ, 8'h00, 8'h3C, 4'd0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{OP_DEQ, 8'h00, 8'h3C, 4'd0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{OP_SEND_ENQ, 8'hA5, 8'h3C, 4'd1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_DEQ, 8'h00, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b1});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{OP_SEND_ENQ, 8'(8'h10 + i), 8'hA5, 4'(i + 1), (i == 7), 1'b0, 1'b1});
    vecs.push_back('{OP_BOTH, 8'h18, 8'h10, 4'd8, 1'b1, 1'b0, 1'b1});

    // Reset state
    wait_n(3);
    chk("rst_status", status_out, 1);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ovf", overflow_out, 0);
    rst = 1'b1;
    wait_n(4);

    // First word 8'h81, status drop after the 8th bit, 3rd-edge enqueue latency
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      send_bit_idx(w, i);
      if (i == 6) chk("status_after7", status_out, 1);
    end
    chk("status_after8", status_out, 0);
    enqueue_in = 1'b1;
    wait_n(2);
    chk("enq_not_yet", count_out, 0);
    enqueue_in = 1'b0;
    wait_n(1);
    chk("enq_count", count_out, 1);
    chk("enq_status", status_out, 1);
    chk("enq_empty", empty_out, 0);
    wait_n(1);

    for (int i = 0; i < split; i++) apply(vecs[i], i);

    // Overflow: queue full, 9th word held
    send_word(8'hF0);
    chk("hold_status", status_out, 0);
    enqueue_in = 1'b1;
    wait_n(2);
    chk("ovf_early", overflow_out, 0);
    enqueue_in = 1'b0;
    wait_n(1);
    chk("ovf_pulse", overflow_out, 1);
    chk("ovf_status", status_out, 0);
    chk("ovf_count", count_out, 8);
    chk("ovf_full", full_out, 1);
    wait_n(1);
    chk("ovf_clear", overflow_out, 0);
    chk("ovf_once", ovf_seen, 1);

    for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-word with strobe held high across release
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    data_in  = 1'b1;
    write_in = 1'b1;
    rst      = 1'b0;
    #1;
    chk("arst_status", status_out, 1);
    chk("arst_count", count_out, 0);
    chk("arst_empty", empty_out, 1);
    chk("arst_full", full_out, 0);
    chk("arst_data", data_out, 0);
    wait_n(2);
    rst = 1'b1;
    wait_n(6);
    write_in = 1'b0;
    wait_n(3);
    chk("no_stale_bit", status_out, 1);
    w = 8'h55;
    for (int i = 0; i < 8; i++) begin
      send_bit_idx(w, i);
      if (i == 6) chk("r55_status7", status_out, 1);
    end
    chk("r55_status8", status_out, 0);
    pulse(1'b1, 1'b0);
    chk("r55_count", count_out, 1);
    pulse(1'b0, 1'b1);
    chk("r55_data", data_out, 8'h55);
    chk("r55_count0", count_out, 0);
    chk("r55_empty", empty_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
